// File: rtl/md_pkg.sv
// md_pkg: shared op codes and default latencies
// for the E-stage multiply/divide unit.
package md_pkg;

  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_countdown.sv
// md_countdown: loadable down-counter; busy while
// nonzero, done asserted in the cycle counting 1->0.
module md_countdown #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         done
);

  logic [W-1:0] count;

  // Count register: load on accept, else step down to zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  // Status decode from the current count
  always_comb begin
    busy = (count != '0);
    done = (count == W'(1));
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide with HI/LO;
// busy stalls the pipe while an op is in flight.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [31:0]        rs_val,
  input  logic [31:0]        rt_val,
  output logic               busy,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  md_op_e        op_in;
  md_op_e        op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;

  logic          acc_mul;
  logic          acc_div;
  logic          acc_mthi;
  logic          acc_mtlo;
  logic          load;
  logic [CW-1:0] load_val;
  logic          done;
  logic          wr_res;

  logic          q_mul;
  logic          q_sgn;
  logic [63:0]   ext_a;
  logic [63:0]   ext_b;
  logic [63:0]   prod;
  logic          neg_a;
  logic          neg_b;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic [31:0]   uq;
  logic [31:0]   ur;
  logic [31:0]   quo;
  logic [31:0]   rem;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;

  // Accept decode: only when idle, reserved code acts as NONE
  always_comb begin
    op_in    = md_op_e'(md_op);
    acc_mul  = 1'b0;
    acc_div  = 1'b0;
    acc_mthi = 1'b0;
    acc_mtlo = 1'b0;
    if (start && !busy) begin
      unique case (1'b1)
        (op_in == MD_MULT),
        (op_in == MD_MULTU): acc_mul  = 1'b1;
        (op_in == MD_DIV),
        (op_in == MD_DIVU):  acc_div  = 1'b1;
        (op_in == MD_MTHI):  acc_mthi = 1'b1;
        (op_in == MD_MTLO):  acc_mtlo = 1'b1;
        default: ;
      endcase
    end
    load     = acc_mul | acc_div;
    load_val = acc_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
  end

  md_countdown #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .busy     (busy),
    .done     (done)
  );

  // Operand/op latch so inputs may change while busy
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= MD_NONE;
      a_q  <= '0;
      b_q  <= '0;
    end else if (load) begin
      op_q <= op_in;
      a_q  <= rs_val;
      b_q  <= rt_val;
    end
  end

  // Datapath on latched operands; divide works on
  // magnitudes so INT_MIN / -1 wraps to INT_MIN, rem 0
  always_comb begin
    q_mul = (op_q == MD_MULT) || (op_q == MD_MULTU);
    q_sgn = (op_q == MD_MULT) || (op_q == MD_DIV);
    ext_a = {{32{q_sgn & a_q[31]}}, a_q};
    ext_b = {{32{q_sgn & b_q[31]}}, b_q};
    prod  = ext_a * ext_b;
    neg_a = q_sgn & a_q[31];
    neg_b = q_sgn & b_q[31];
    mag_a = neg_a ? (~a_q + 32'd1) : a_q;
    mag_b = neg_b ? (~b_q + 32'd1) : b_q;
    uq    = mag_a / mag_b;
    ur    = mag_a % mag_b;
    quo   = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    rem   = neg_a ? (~ur + 32'd1) : ur;
    if (q_mul) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
    wr_res = done && (q_mul || (b_q != '0));
  end

  // HI/LO: result write on completion, MTHI/MTLO on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (wr_res) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (acc_mthi) begin
      hi <= rs_val;
    end else if (acc_mtlo) begin
      lo <= rs_val;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit;
// expected HI/LO/latency queued at issue, popped at completion.
module tb_md_unit;
  import md_pkg::*;

  logic               clk;
  logic               reset;
  logic               start;
  logic [MD_OP_W-1:0] md_op;
  logic [31:0]        rs_val;
  logic [31:0]        rt_val;
  logic               busy;
  logic [31:0]        hi;
  logic [31:0]        lo;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_err;

  md_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Issue one op, optionally re-poke start/operands
  // during busy, then count busy cycles and score.
  task automatic issue(input string tag,
                       input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] ehi,
                       input logic [31:0] elo,
                       input int ecyc,
                       input bit poke);
    exp_t e;
    exp_t g;
    int n;
    e.tag = tag;
    e.hi  = ehi;
    e.lo  = elo;
    e.cyc = ecyc;
    @(negedge clk);
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
    n = 0;
    while (busy && n < 64) begin
      n++;
      if (poke && n == 2) begin
        start  = 1'b1;
        md_op  = MD_MULT;
        rs_val = 32'd100;
        rt_val = 32'd100;
      end else begin
        start = 1'b0;
        md_op = 3'd0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    g = sb.pop_front();
    check({g.tag, ".cyc"}, 32'(n), 32'(g.cyc));
    check({g.tag, ".hi"}, hi, g.hi);
    check({g.tag, ".lo"}, lo, g.lo);
  endtask

  initial begin
    int n;
    n_chk  = 0;
    n_err  = 0;
    reset  = 1'b1;
    start  = 1'b0;
    md_op  = 3'd0;
    rs_val = '0;
    rt_val = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.hi", hi, 32'd0);
    check("rst.lo", lo, 32'd0);

    issue("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3,
          32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b0);
    issue("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2,
          32'h0000_0001, 32'hFFFF_FFFE, 5, 1'b0);
    issue("div", MD_DIV, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0);
    issue("mthi11", MD_MTHI, 32'h11, 32'd0,
          32'h11, 32'hFFFF_FFFD, 0, 1'b0);
    issue("mtlo22", MD_MTLO, 32'h22, 32'd0,
          32'h11, 32'h22, 0, 1'b0);
    issue("divu0", MD_DIVU, 32'd7, 32'd0,
          32'h11, 32'h22, 10, 1'b0);
    issue("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h0, 32'h8000_0000, 10, 1'b0);
    issue("mthi", MD_MTHI, 32'hDEAD_BEEF, 32'd0,
          32'hDEAD_BEEF, 32'h8000_0000, 0, 1'b0);
    issue("rsvd", 3'd7, 32'd1, 32'd1,
          32'hDEAD_BEEF, 32'h8000_0000, 0, 1'b0);
    issue("reiss", MD_MULT, 32'd3, 32'd4,
          32'h0, 32'hC, 5, 1'b1);
    issue("divu", MD_DIVU, 32'd100, 32'd7,
          32'd2, 32'd14, 10, 1'b0);
    issue("divneg", MD_DIV, 32'd7, 32'hFFFF_FFFE,
          32'd1, 32'hFFFF_FFFD, 10, 1'b0);
    issue("mult11", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'h0, 32'h1, 5, 1'b0);
    issue("multumax", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 32'h1, 5, 1'b0);

    // Reset in busy cycle 4 of a divide
    @(negedge clk);
    start  = 1'b1;
    md_op  = MD_DIV;
    rs_val = 32'd100;
    rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
    n = 1;
    while (busy && n < 4) begin
      n++;
      @(negedge clk);
    end
    check("rstmid.cyc", 32'(n), 32'd4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid.busy", 32'(busy), 32'd0);
    check("rstmid.hi", hi, 32'd0);
    check("rstmid.lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    check("rstlate.busy", 32'(busy), 32'd0);
    check("rstlate.hi", hi, 32'd0);
    check("rstlate.lo", lo, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
